adau1761_cfg_sequencer: RTL

//  Table-driven configuration scheduler for the ADAU1761 codec.

---
 rtl/adau1761_cfg_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/adau1761_cfg_sequencer.sv
// rtl/adau1761_cfg_sequencer.sv - table-driven ADAU1761 configuration sequencer
module adau1761_cfg_sequencer #(
  parameter logic [6:0]  DEV_ADDR   = 7'h3B,
  parameter int          TBL_AW     = 6,
  parameter int unsigned BOOT_DLY   = 1_500_000,
  parameter int unsigned DELAY_UNIT = 100_000,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned MAX_POLL   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [25:0]       tbl_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_rw,
  output logic [6:0]        cmd_dev,
  output logic [15:0]       cmd_reg,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic              rsp_nack,
  input  logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_error,
  output logic [TBL_AW-1:0] err_idx,
  output logic              i2s_en
);

  localparam logic [2:0] S_BOOT     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_DECODE   = 3'd2;
  localparam logic [2:0] S_ISSUE    = 3'd3;
  localparam logic [2:0] S_WAIT_RSP = 3'd4;
  localparam logic [2:0] S_DELAY    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;
  localparam logic [2:0] S_ERR      = 3'd7;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_DELAY = 2'd2;
  localparam logic [1:0] OP_END   = 2'd3;

  localparam logic [TBL_AW-1:0] IDX_LAST = '1;

  logic [2:0]        state;
  logic [TBL_AW-1:0] idx;
  logic [1:0]        op_q;
  logic [15:0]       reg_q;
  logic [7:0]        data_q;
  logic [31:0]       cnt;
  logic [31:0]       dly_len;
  logic              dly_poll;
  logic [31:0]       retry_cnt;
  logic [31:0]       poll_cnt;
  logic              poll_met;
  logic              delay_over;
  logic              advance;

  assign poll_met   = (rsp_rdata & data_q) == data_q;
  assign delay_over = cnt >= dly_len;

  // Both the response path and the end of a table DELAY step move to the next entry.
  always_comb begin
    advance = 1'b0;
    if (state == S_WAIT_RSP && rsp_valid && !rsp_nack && (op_q == OP_WRITE || poll_met))
      advance = 1'b1;
    if (state == S_DELAY && delay_over && !dly_poll)
      advance = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_BOOT;
      idx       <= '0;
      op_q      <= OP_WRITE;
      reg_q     <= '0;
      data_q    <= '0;
      cnt       <= '0;
      dly_len   <= '0;
      dly_poll  <= 1'b0;
      retry_cnt <= '0;
      poll_cnt  <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          if (cnt + 32'd1 >= BOOT_DLY) begin
            cnt   <= '0;
            state <= S_FETCH;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          op_q   <= tbl_data[25:24];
          reg_q  <= tbl_data[23:8];
          data_q <= tbl_data[7:0];
          cnt    <= '0;
          case (tbl_data[25:24])
            OP_WRITE, OP_POLL: state <= S_ISSUE;
            OP_DELAY: begin
              dly_len  <= 32'(tbl_data[7:0]) * DELAY_UNIT;
              dly_poll <= 1'b0;
              state    <= S_DELAY;
            end
            default: state <= S_DONE;
          endcase
        end
        S_ISSUE: begin
          if (cmd_ready)
            state <= S_WAIT_RSP;
        end
        S_WAIT_RSP: begin
          if (rsp_valid) begin
            if (rsp_nack) begin
              retry_cnt <= retry_cnt + 32'd1;
              state     <= (retry_cnt + 32'd1 <= MAX_RETRY) ? S_ISSUE : S_ERR;
            end else if (op_q == OP_POLL && !poll_met) begin
              poll_cnt <= poll_cnt + 32'd1;
              if (poll_cnt + 32'd1 < MAX_POLL) begin
                dly_len  <= DELAY_UNIT;
                dly_poll <= 1'b1;
                cnt      <= '0;
                state    <= S_DELAY;
              end else begin
                state <= S_ERR;
              end
            end
          end
        end
        S_DELAY: begin
          if (delay_over) begin
            cnt <= '0;
            if (dly_poll)
              state <= S_ISSUE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            idx       <= '0;
            retry_cnt <= '0;
            poll_cnt  <= '0;
            cnt       <= '0;
            state     <= S_FETCH;
          end
        end
        default: state <= S_BOOT;
      endcase

      // The last table slot finishes the run rather than wrapping to entry 0.
      if (advance) begin
        retry_cnt <= '0;
        poll_cnt  <= '0;
        if (idx == IDX_LAST) begin
          state <= S_DONE;
        end else begin
          idx   <= idx + TBL_AW'(1);
          state <= S_FETCH;
        end
      end
    end
  end

  assign tbl_addr  = idx;
  assign cmd_valid = (state == S_ISSUE);
  assign cmd_rw    = (op_q == OP_POLL);
  assign cmd_dev   = DEV_ADDR;
  assign cmd_reg   = reg_q;
  assign cmd_wdata = data_q;
  assign busy      = (state != S_DONE) && (state != S_ERR);
  assign cfg_done  = (state == S_DONE);
  assign cfg_error = (state == S_ERR);
  assign err_idx   = cfg_error ? idx : '0;
  assign i2s_en    = cfg_done;

endmodule
